// File: rtl/cond_unit_it.sv
// Execute-stage conditional unit: NZCV register with per-flag enables, IT-block
// sequencing, banked saved flags, and condition-gated write controls.
module cond_unit_it #(
  parameter int BANKS  = 2,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter bit IT_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [3:0]        Cond,
  input  logic [3:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              MS,
  input  logic              NoWrite,
  input  logic              LogicOp,
  input  logic [3:0]        ALUFlags,
  input  logic              ShifterCarry,
  input  logic              ITStart,
  input  logic [3:0]        ITCond,
  input  logic [3:0]        ITMask,
  input  logic              SaveFlags,
  input  logic [BANK_W-1:0] SaveIdx,
  input  logic              RestoreFlags,
  input  logic [BANK_W-1:0] RestIdx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              MStart,
  output logic              CondEx,
  output logic [3:0]        Flags,
  output logic              CFlag,
  output logic              InIT,
  output logic [7:0]        ITState,
  output logic              ITErr
);
  localparam logic [3:0] AL = 4'b1110;

  logic [3:0]            nzcv;
  logic [BANKS-1:0][3:0] bank;
  logic [7:0]            it_state;
  logic                  it_err;
  logic                  in_it;
  logic                  cond_ex;
  logic [3:0]            eff_cond;

  // f = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = cy;
      4'h3: cond_pass = ~cy;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = cy & ~z;
      4'h9: cond_pass = ~cy | z;
      4'ha: cond_pass = (n == v);
      4'hb: cond_pass = (n != v);
      4'hc: cond_pass = ~z & (n == v);
      4'hd: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  always_comb begin
    in_it    = IT_EN && (it_state[3:0] != 4'h0);
    eff_cond = Cond;
    if (IT_EN && ITStart) eff_cond = AL;
    else if (in_it)       eff_cond = it_state[7:4];
    cond_ex  = Valid & cond_pass(eff_cond, nzcv);
  end

  assign CondEx   = cond_ex;
  assign PCSrc    = ~Flush & PCS & cond_ex;
  assign RegWrite = ~Flush & RegW & cond_ex & ~NoWrite;
  assign MemWrite = ~Flush & MemW & cond_ex;
  assign MStart   = ~Flush & MS & cond_ex;
  assign Flags    = nzcv;
  assign CFlag    = nzcv[1];
  assign InIT     = in_it;
  assign ITState  = it_state;
  assign ITErr    = it_err;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      nzcv     <= 4'h0;
      bank     <= '0;
      it_state <= 8'h00;
      it_err   <= 1'b0;
    end else if (Stall) begin
      it_err <= 1'b0;
    end else begin
      // restore wins over a same-cycle flag write; save sees pre-update flags
      if (RestoreFlags) begin
        if (32'(RestIdx) < BANKS) nzcv <= bank[RestIdx];
      end else if (!Flush) begin
        for (int i = 0; i < 4; i++)
          if (FlagW[i] & cond_ex)
            nzcv[i] <= (i == 1 && LogicOp) ? ShifterCarry : ALUFlags[i];
      end
      if (SaveFlags && 32'(SaveIdx) < BANKS) bank[SaveIdx] <= nzcv;

      it_err <= 1'b0;
      if (IT_EN) begin
        if (Flush) begin
          it_state <= 8'h00;
        end else if (Valid) begin
          if (in_it) begin
            if (ITStart) it_err <= 1'b1;
            // the shifted-out mask bit becomes the LSB of the next condition
            if (it_state[2:0] == 3'b000) it_state <= 8'h00;
            else                         it_state[4:0] <= {it_state[3:0], 1'b0};
          end else if (ITStart) begin
            if (ITMask == 4'h0) it_err   <= 1'b1;
            else                it_state <= {ITCond, ITMask};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_cond_unit_it.sv
// Bench for cond_unit_it: directed test-plan steps followed by random cycles,
// every cycle checked against an IT-block/flag reference model.
module tb_cond_unit_it;
  localparam int BANKS = 2;
  localparam int BANK_W = 1;

  logic CLK = 1'b0;
  logic Reset, Valid, Stall, Flush;
  logic [3:0] Cond, FlagW, ALUFlags, ITCond, ITMask;
  logic PCS, RegW, MemW, MS, NoWrite, LogicOp, ShifterCarry, ITStart;
  logic SaveFlags, RestoreFlags;
  logic [BANK_W-1:0] SaveIdx, RestIdx;
  logic PCSrc, RegWrite, MemWrite, MStart, CondEx, CFlag, InIT, ITErr;
  logic [3:0] Flags;
  logic [7:0] ITState;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: IT block as firstcond, mask and instruction count so far
  logic [3:0] m_nzcv;
  logic [3:0] m_bank [BANKS];
  logic       m_act, m_err;
  logic [3:0] m_fc, m_mask;
  int         m_p;

  cond_unit_it #(.BANKS(BANKS), .BANK_W(BANK_W), .IT_EN(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .Cond(Cond), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .MS(MS),
    .NoWrite(NoWrite), .LogicOp(LogicOp), .ALUFlags(ALUFlags),
    .ShifterCarry(ShifterCarry), .ITStart(ITStart), .ITCond(ITCond),
    .ITMask(ITMask), .SaveFlags(SaveFlags), .SaveIdx(SaveIdx),
    .RestoreFlags(RestoreFlags), .RestIdx(RestIdx), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MStart(MStart), .CondEx(CondEx),
    .Flags(Flags), .CFlag(CFlag), .InIT(InIT), .ITState(ITState), .ITErr(ITErr)
  );

  always #5 CLK = ~CLK;

  function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      default: return 1;
    endcase
  endfunction

  function automatic int it_len(input logic [3:0] m);
    if (m[0]) return 4;
    if (m[1]) return 3;
    if (m[2]) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] m_cur_cond();
    if (m_p == 0) return m_fc;
    return {m_fc[3:1], m_mask[4-m_p]};
  endfunction

  function automatic logic [7:0] m_itstate();
    logic [4:0] low;
    if (!m_act) return 8'h00;
    low = 5'({m_fc[0], m_mask} << m_p);
    return {m_fc[3:1], low};
  endfunction

  function automatic bit m_condex();
    logic [3:0] eff;
    eff = ITStart ? 4'he : (m_act ? m_cur_cond() : Cond);
    return Valid && passes(eff, m_nzcv);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    bit ex;
    ex = m_condex();
    chk("CondEx", 8'(CondEx), 8'(ex));
    chk("PCSrc", 8'(PCSrc), 8'(!Flush && PCS && ex));
    chk("RegWrite", 8'(RegWrite), 8'(!Flush && RegW && ex && !NoWrite));
    chk("MemWrite", 8'(MemWrite), 8'(!Flush && MemW && ex));
    chk("MStart", 8'(MStart), 8'(!Flush && MS && ex));
  endtask

  task automatic check_state();
    chk("Flags", 8'(Flags), 8'(m_nzcv));
    chk("CFlag", 8'(CFlag), 8'(m_nzcv[1]));
    chk("InIT", 8'(InIT), 8'(m_act));
    chk("ITState", ITState, m_itstate());
    chk("ITErr", 8'(ITErr), 8'(m_err));
  endtask

  task automatic model_step();
    bit ex;
    logic [3:0] old;
    ex = m_condex();
    if (!Reset) begin
      m_nzcv = 0; m_act = 0; m_err = 0; m_p = 0;
      for (int i = 0; i < BANKS; i++) m_bank[i] = 0;
    end else if (Stall) begin
      m_err = 0;
    end else begin
      old = m_nzcv;
      if (RestoreFlags) m_nzcv = m_bank[RestIdx];
      else if (!Flush && ex) begin
        if (FlagW[3]) m_nzcv[3] = ALUFlags[3];
        if (FlagW[2]) m_nzcv[2] = ALUFlags[2];
        if (FlagW[1]) m_nzcv[1] = LogicOp ? ShifterCarry : ALUFlags[1];
        if (FlagW[0]) m_nzcv[0] = ALUFlags[0];
      end
      if (SaveFlags) m_bank[SaveIdx] = old;
      m_err = 0;
      if (Flush) m_act = 0;
      else if (Valid) begin
        if (m_act) begin
          if (ITStart) m_err = 1;
          m_p++;
          if (m_p == it_len(m_mask)) m_act = 0;
        end else if (ITStart) begin
          if (ITMask == 0) m_err = 1;
          else begin m_act = 1; m_fc = ITCond; m_mask = ITMask; m_p = 0; end
        end
      end
    end
  endtask

  task automatic cyc();
    #1 check_comb();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_state();
  endtask

  task automatic idle();
    Reset = 1; Valid = 0; Stall = 0; Flush = 0; Cond = 4'he; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; MS = 0; NoWrite = 0; LogicOp = 0;
    ALUFlags = 0; ShifterCarry = 0; ITStart = 0; ITCond = 0; ITMask = 0;
    SaveFlags = 0; SaveIdx = 0; RestoreFlags = 0; RestIdx = 0;
  endtask

  initial begin
    m_nzcv = 0; m_act = 0; m_err = 0; m_p = 0; m_fc = 0; m_mask = 0;
    for (int i = 0; i < BANKS; i++) m_bank[i] = 0;
    idle();
    @(negedge CLK);

    // reset with flag writes requested
    Reset = 0; Valid = 1; FlagW = 4'hf; ALUFlags = 4'hf;
    cyc(); cyc();
    chk("rst_flags", 8'(Flags), 8'h0);
    chk("rst_itstate", ITState, 8'h00);
    idle(); Valid = 1; RegW = 1;
    #1 chk("al_regwrite", 8'(RegWrite), 8'h1);
    cyc();

    // logical carry
    idle(); Valid = 1; FlagW = 4'b0010; LogicOp = 1; ShifterCarry = 1;
    cyc(); chk("logic_c1", 8'(CFlag), 8'h1);
    LogicOp = 0;
    cyc(); chk("logic_c0", 8'(CFlag), 8'h0);

    // ITTE EQ with Z=1, bubble mid-block
    idle(); Valid = 1; FlagW = 4'hf; ALUFlags = 4'b0100; cyc();
    idle(); Valid = 1; ITStart = 1; ITCond = 4'h0; ITMask = 4'b0110; cyc();
    chk("itte_start", ITState, 8'h06);
    idle(); Valid = 1; RegW = 1;
    #1 chk("itte_i1", 8'(RegWrite), 8'h1); cyc();
    Valid = 0; cyc(); chk("itte_bubble", ITState, 8'h0c);
    Valid = 1;
    #1 chk("itte_i2", 8'(RegWrite), 8'h1); cyc();
    #1 chk("itte_i3", 8'(RegWrite), 8'h0); cyc();
    chk("itte_end", 8'(InIT), 8'h0);

    // stall then flush inside a block
    idle(); Valid = 1; ITStart = 1; ITCond = 4'h0; ITMask = 4'b0110; cyc();
    idle(); Valid = 1; RegW = 1; cyc();
    Stall = 1;
    for (int i = 0; i < 3; i++) begin cyc(); chk("stall_hold", ITState, 8'h0c); end
    Stall = 0; Flush = 1;
    #1 chk("flush_regw", 8'(RegWrite), 8'h0); cyc();
    chk("flush_it", ITState, 8'h00);

    // bank save/restore
    idle(); Valid = 1; FlagW = 4'hf; ALUFlags = 4'b1010; cyc();
    idle(); SaveFlags = 1; SaveIdx = 1; cyc();
    idle(); Valid = 1; FlagW = 4'hf; ALUFlags = 4'b0101; cyc();
    chk("bank_mid", 8'(Flags), 8'h5);
    RestoreFlags = 1; RestIdx = 1; cyc();
    chk("bank_restore", 8'(Flags), 8'ha);

    // nested IT and illegal mask
    idle(); Valid = 1; ITStart = 1; ITCond = 4'he; ITMask = 4'b0001; cyc();
    cyc();
    chk("nest_err", 8'(ITErr), 8'h1);
    chk("nest_shift", ITState, 8'he2);
    idle(); cyc(); chk("nest_pulse", 8'(ITErr), 8'h0);
    Flush = 1; cyc();
    idle(); Valid = 1; ITStart = 1; ITMask = 4'h0; cyc();
    chk("mask0_err", 8'(ITErr), 8'h1);
    chk("mask0_init", 8'(InIT), 8'h0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      Reset = ($urandom_range(0, 63) != 0);
      Valid = ($urandom_range(0, 3) != 0);
      Stall = ($urandom_range(0, 7) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      Cond = 4'($urandom); FlagW = 4'($urandom); ALUFlags = 4'($urandom);
      PCS = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom);
      MS = 1'($urandom); NoWrite = ($urandom_range(0, 3) == 0);
      LogicOp = 1'($urandom); ShifterCarry = 1'($urandom);
      ITStart = ($urandom_range(0, 5) == 0);
      ITCond = 4'($urandom);
      ITMask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      SaveFlags = ($urandom_range(0, 7) == 0); SaveIdx = 1'($urandom);
      RestoreFlags = ($urandom_range(0, 7) == 0); RestIdx = 1'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
